slave_dtack_watchdog: RTL and testbench
=======================================

# slave_dtack_watchdog

Timeout guard for Zorro III slave cycles on the A4092 CPLD. Monitors the slave cycle state machine's data phase and the OR of all target dtacks (autoconfig, SCSI, ROM, SPI, SID, IACK). If no target answers within a bounded time, it forces termination so the host never hangs on a stalled NCR/ROM access. Each timeout is logged in a sticky status byte readable by driver code.

## Interface
- TIMEOUT_CYCLES, 256, CLK cycles from data-phase entry to forced termination; legal range 2..65535 (256 = 10.24 µs at 25 MHz).
- CNT_W, $clog2(TIMEOUT_CYCLES), counter width; derived, never overridden.
- CLK  in  1  25 MHz board clock.
- RESET_n  in  1  asynchronous, active-low reset (IORST_n).
- FCS_n  in  1  buffered Zorro cycle strobe, active low (!bfcs).
- data_phase  in  1  high while the slave FSM is in its DATA state.
- dev_dtack  in  1  OR of all target dtack requests.
- READ  in  1  Zorro READ, sampled at expiry.
- region  in  2  target decode: 0 ROM, 1 SCSI, 2 INTREG, 3 IDREG.
- status_rd  in  1  one-cycle pulse; reading the status register clears it.
- to_dtack  out  1  forced termination request, ORed into the slave FSM's dtack inputs.
- to_drive_ones  out  1  on a timed-out read, D[31:0] is driven with 0xFFFFFFFF.
- status  out  8  {sticky, read, region[1:0], 1'b0, count[2:0]}.
- to_irq  out  1  timeout interrupt request (see Configuration).

## Operation
- States: IDLE, ARMED, ANSWERED, EXPIRED.
- IDLE: counter = 0. If FCS_n = 0 and data_phase = 1, go to ARMED.
- ARMED: counter increments by 1 each cycle.
  - dev_dtack = 1: go to ANSWERED.
  - Else if counter == TIMEOUT_CYCLES-1: go to EXPIRED.
  - FCS_n = 1: go to IDLE.
- ANSWERED: wait for FCS_n = 1, then go to IDLE. No logging.
- EXPIRED:
  - to_dtack = 1.
  - to_drive_ones = READ as latched on entry.
  - On FCS_n = 1: go to IDLE and deassert both.
- Logging on entry to EXPIRED:
  - sticky set to 1.
  - read and region latched from current inputs.
  - count incremented, saturating at 7.
- status_rd = 1: sticky, read, region and count cleared.
- Priorities:
  - dev_dtack and counter terminal in the same cycle: dev_dtack wins, no timeout.
  - FCS_n rising in the same cycle as the terminal count: IDLE wins, no timeout.
  - status_rd in the same cycle as expiry logging: the log wins; after that edge sticky = 1 and count = 1.
- data_phase is only used for arming; later deassertion does not abort ARMED.
- Reset values (RESET_n low, any time, including mid-cycle):
  - state IDLE, counter 0.
  - to_dtack 0, to_drive_ones 0.
  - status 8'h00, to_irq 0.

## Timing
- All state and outputs are registered on posedge CLK; the only asynchronous path is RESET_n.
- If ARMED is entered at edge E0 and dev_dtack stays low, to_dtack goes high after edge E(TIMEOUT_CYCLES).
- status updates on that same edge.
- to_dtack and to_drive_ones go low one edge after FCS_n is sampled high.
- status_rd takes effect on the next edge (1-cycle latency).
- A back-to-back cycle needs at least one IDLE cycle, which FCS_n high guarantees.

## Configuration
- Macro DTACK_TIMEOUT_IRQ_EN.
- Defined: to_irq = status sticky bit. It is a level output, cleared by status_rd, and combined into INT2_n by the top level.
- Undefined: to_irq is tied to 0 and no IRQ logic is synthesized. status behaves identically in both builds.

## Test plan
- TIMEOUT_CYCLES=16, SCSI read (region 1, READ 1), dev_dtack never asserted -> to_dtack and to_drive_ones rise 16 edges after arming; status = 8'hD1; to_irq = 1 with the macro, 0 without.
- dev_dtack at arming+5 -> ANSWERED; to_dtack stays 0; status stays 8'h00.
- dev_dtack on the exact terminal cycle (arming+15) -> no timeout; status 8'h00.
- Nine consecutive timed-out ROM writes -> count saturates at 7; status = 8'h87. A status_rd pulse then gives 8'h00.
- status_rd coincident with an expiry edge -> status count = 1, sticky = 1.
- RESET_n asserted while EXPIRED -> to_dtack = 0 immediately (asynchronously), status 8'h00; the next cycle arms normally.

Source files
------------

// File: rtl/slave_dtack_watchdog_if.sv
// -----------------------------------------------------------------------------
// slave_dtack_watchdog_if
// Bundle of the Zorro III slave-cycle signals watched by the dtack watchdog.
//   FCS_n         buffered Zorro cycle strobe, active low
//   data_phase    slave FSM is in its DATA state
//   dev_dtack     OR of all target dtack requests
//   READ          Zorro READ
//   region        target decode: 0 ROM, 1 SCSI, 2 INTREG, 3 IDREG
//   status_rd     one-cycle pulse, reading status clears it
//   to_dtack      forced termination request
//   to_drive_ones drive D[31:0] with all ones on a timed-out read
//   status        {sticky, read, region[1:0], 1'b0, count[2:0]}
//   to_irq        timeout interrupt request
// Modport slave is the watchdog side, master is the surrounding logic.
// -----------------------------------------------------------------------------
interface slave_dtack_watchdog_if;
    logic       FCS_n;
    logic       data_phase;
    logic       dev_dtack;
    logic       READ;
    logic [1:0] region;
    logic       status_rd;
    logic       to_dtack;
    logic       to_drive_ones;
    logic [7:0] status;
    logic       to_irq;

    modport slave (
        input  FCS_n, data_phase, dev_dtack, READ, region, status_rd,
        output to_dtack, to_drive_ones, status, to_irq
    );

    modport master (
        output FCS_n, data_phase, dev_dtack, READ, region, status_rd,
        input  to_dtack, to_drive_ones, status, to_irq
    );
endinterface

// File: rtl/slave_dtack_watchdog.sv
// -----------------------------------------------------------------------------
// slave_dtack_watchdog
// Timeout guard for Zorro III slave cycles. Once the slave FSM enters its data
// phase, a counter runs until a target answers. If nobody answers within
// TIMEOUT_CYCLES clocks, the watchdog requests termination itself (and all
// ones on reads) so the host never hangs, and logs the event in a sticky
// status byte.
// Ports:
//   CLK      25 MHz board clock
//   RESET_n  asynchronous active-low reset (IORST_n)
//   bus      slave_dtack_watchdog_if.slave (handshake, status, irq)
// Optional feature: define DTACK_TIMEOUT_IRQ_EN to drive to_irq from the
// sticky bit; otherwise to_irq is tied low.
// -----------------------------------------------------------------------------
module slave_dtack_watchdog #(
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                   CLK,
    input  logic                   RESET_n,
    slave_dtack_watchdog_if.slave  bus
);

    localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ANSWERED = 2'd2,
        EXPIRED  = 2'd3
    } wd_state_t;

    wd_state_t        state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             to_dtack_r;
    logic             to_drive_ones_r;
    logic             sticky_r;
    logic             read_r;
    logic [1:0]       region_r;
    logic [2:0]       count_r;

    // Timeout counter that sticks at 7 instead of wrapping
    function automatic logic [2:0] sat_inc3(input logic [2:0] v);
        sat_inc3 = (v == 3'd7) ? 3'd7 : (v + 3'd1);
    endfunction

    // Watchdog FSM, forced-termination outputs and timeout log
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_r         <= IDLE;
            cnt_r           <= '0;
            to_dtack_r      <= 1'b0;
            to_drive_ones_r <= 1'b0;
            sticky_r        <= 1'b0;
            read_r          <= 1'b0;
            region_r        <= 2'd0;
            count_r         <= 3'd0;
        end else begin
            // A status read clears the log; an expiry below overrides it.
            if (bus.status_rd) begin
                sticky_r <= 1'b0;
                read_r   <= 1'b0;
                region_r <= 2'd0;
                count_r  <= 3'd0;
            end else begin
                sticky_r <= sticky_r;
            end

            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (!bus.FCS_n && bus.data_phase) begin
                        state_r <= ARMED;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ARMED: begin
                    // Target answer beats strobe release, which beats expiry.
                    if (bus.dev_dtack) begin
                        state_r <= ANSWERED;
                        cnt_r   <= '0;
                    end else if (bus.FCS_n) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                    end else if (cnt_r == TERM_C) begin
                        state_r         <= EXPIRED;
                        cnt_r           <= '0;
                        to_dtack_r      <= 1'b1;
                        to_drive_ones_r <= bus.READ;
                        sticky_r        <= 1'b1;
                        read_r          <= bus.READ;
                        region_r        <= bus.region;
                        // A read landing on the logging edge clears first.
                        count_r         <= bus.status_rd ? 3'd1 : sat_inc3(count_r);
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ANSWERED: begin
                    if (bus.FCS_n) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= ANSWERED;
                    end
                end
                EXPIRED: begin
                    if (bus.FCS_n) begin
                        state_r         <= IDLE;
                        to_dtack_r      <= 1'b0;
                        to_drive_ones_r <= 1'b0;
                    end else begin
                        state_r <= EXPIRED;
                    end
                end
                default: begin
                    state_r         <= IDLE;
                    cnt_r           <= '0;
                    to_dtack_r      <= 1'b0;
                    to_drive_ones_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.to_dtack      = to_dtack_r;
    assign bus.to_drive_ones = to_drive_ones_r;
    assign bus.status        = {sticky_r, read_r, region_r, 1'b0, count_r};

`ifdef DTACK_TIMEOUT_IRQ_EN
    // Level interrupt follows the sticky bit, cleared by a status read.
    assign bus.to_irq = sticky_r;
`else
    assign bus.to_irq = 1'b0;
`endif

endmodule

// File: tb/tb_slave_dtack_watchdog.sv
module tb_slave_dtack_watchdog;

    localparam int TO_C = 16;
`ifdef DTACK_TIMEOUT_IRQ_EN
    localparam logic [7:0] IRQ_EXP_C = 8'h01;
`else
    localparam logic [7:0] IRQ_EXP_C = 8'h00;
`endif

    logic CLK = 1'b0;
    logic RESET_n;
    int   n_cmp = 0;
    int   n_err = 0;

    slave_dtack_watchdog_if bus();

    slave_dtack_watchdog #(.TIMEOUT_CYCLES(TO_C)) dut (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // advance n rising edges, landing 1 time unit after the last one
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // strobe + data phase sampled on the next edge (E0), then drop data_phase
    task automatic arm();
        bus.FCS_n      = 1'b0;
        bus.data_phase = 1'b1;
        tick(1);
        bus.data_phase = 1'b0;
    endtask

    task automatic end_cycle();
        bus.FCS_n = 1'b1;
        tick(2);
    endtask

    task automatic status_read();
        bus.status_rd = 1'b1;
        tick(1);
        bus.status_rd = 1'b0;
    endtask

    initial begin
        RESET_n        = 1'b0;
        bus.FCS_n      = 1'b1;
        bus.data_phase = 1'b0;
        bus.dev_dtack  = 1'b0;
        bus.READ       = 1'b0;
        bus.region     = 2'd0;
        bus.status_rd  = 1'b0;
        tick(2);
        chk("rst_dtack", 8'(bus.to_dtack), 8'h00);
        chk("rst_ones",  8'(bus.to_drive_ones), 8'h00);
        chk("rst_status", bus.status, 8'h00);
        chk("rst_irq",   8'(bus.to_irq), 8'h00);
        RESET_n = 1'b1;
        tick(2);

        // SCSI read, nobody answers
        bus.region = 2'd1;
        bus.READ   = 1'b1;
        arm();
        tick(15);
        chk("scsi_before_term", 8'(bus.to_dtack), 8'h00);
        tick(1);
        chk("scsi_dtack",  8'(bus.to_dtack), 8'h01);
        chk("scsi_ones",   8'(bus.to_drive_ones), 8'h01);
        chk("scsi_status", bus.status, 8'hD1);
        chk("scsi_irq",    8'(bus.to_irq), IRQ_EXP_C);
        bus.READ = 1'b0;
        tick(1);
        chk("scsi_ones_latched", 8'(bus.to_drive_ones), 8'h01);
        bus.FCS_n = 1'b1;
        tick(1);
        chk("scsi_dtack_release", 8'(bus.to_dtack), 8'h00);
        chk("scsi_ones_release",  8'(bus.to_drive_ones), 8'h00);
        chk("scsi_status_held",   bus.status, 8'hD1);
        tick(1);
        status_read();
        chk("scsi_status_clr", bus.status, 8'h00);
        chk("scsi_irq_clr",    8'(bus.to_irq), 8'h00);

        // target answers at arming+5
        arm();
        tick(4);
        bus.dev_dtack = 1'b1;
        tick(1);
        bus.dev_dtack = 1'b0;
        tick(20);
        chk("ans5_dtack",  8'(bus.to_dtack), 8'h00);
        chk("ans5_status", bus.status, 8'h00);
        end_cycle();

        // target answers on the terminal cycle
        arm();
        tick(15);
        bus.dev_dtack = 1'b1;
        tick(1);
        bus.dev_dtack = 1'b0;
        chk("term_ans_dtack", 8'(bus.to_dtack), 8'h00);
        tick(3);
        chk("term_ans_status", bus.status, 8'h00);
        end_cycle();

        // strobe released on the terminal cycle
        arm();
        tick(15);
        bus.FCS_n = 1'b1;
        tick(1);
        chk("term_fcs_dtack", 8'(bus.to_dtack), 8'h00);
        tick(2);
        chk("term_fcs_status", bus.status, 8'h00);

        // nine timed-out ROM writes, count saturates
        bus.region = 2'd0;
        bus.READ   = 1'b0;
        for (int i = 0; i < 9; i++) begin
            arm();
            tick(16);
            if (i == 0) begin
                chk("rom_dtack", 8'(bus.to_dtack), 8'h01);
                chk("rom_ones",  8'(bus.to_drive_ones), 8'h00);
            end
            end_cycle();
        end
        chk("rom_sat_status", bus.status, 8'h87);
        status_read();
        chk("rom_status_clr", bus.status, 8'h00);

        // status_rd on the expiry edge: log wins, count restarts at 1
        bus.region = 2'd2;
        bus.READ   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            arm();
            tick(16);
            end_cycle();
        end
        chk("coin_pre_status", bus.status, 8'hE2);
        arm();
        tick(15);
        bus.status_rd = 1'b1;
        tick(1);
        bus.status_rd = 1'b0;
        chk("coin_status", bus.status, 8'hE1);
        chk("coin_irq",    8'(bus.to_irq), IRQ_EXP_C);
        end_cycle();
        status_read();

        // asynchronous reset while EXPIRED
        bus.region = 2'd3;
        bus.READ   = 1'b0;
        arm();
        tick(16);
        chk("rst_exp_pre", 8'(bus.to_dtack), 8'h01);
        #2;
        RESET_n = 1'b0;
        #1;
        chk("rst_exp_dtack",  8'(bus.to_dtack), 8'h00);
        chk("rst_exp_status", bus.status, 8'h00);
        chk("rst_exp_irq",    8'(bus.to_irq), 8'h00);
        bus.FCS_n = 1'b1;
        tick(1);
        RESET_n = 1'b1;
        tick(1);
        arm();
        tick(16);
        chk("post_rst_dtack",  8'(bus.to_dtack), 8'h01);
        chk("post_rst_status", bus.status, 8'hB1);
        end_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
